// File: rtl/regfile_write_arbiter_if.sv
// Bundles the writeback, I/O and exception request signals with the regfile write port.
// master = pipeline/requesters side, slave = arbiter side.
interface regfile_write_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        io_valid;
  logic [4:0]  io_reg;
  logic [31:0] io_data;
  logic        io_ready;
  logic        exc_valid;
  logic [31:0] exc_code;
  logic        stall_wb;
  logic        exc_overrun;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  modport master (
    output wb_we, wb_reg, wb_data,
    output io_valid, io_reg, io_data,
    input  io_ready,
    output exc_valid, exc_code,
    input  stall_wb, exc_overrun,
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );

  modport slave (
    input  wb_we, wb_reg, wb_data,
    input  io_valid, io_reg, io_data,
    output io_ready,
    input  exc_valid, exc_code,
    output stall_wb, exc_overrun,
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the regfile write port: WB > pending exception (r30) > I/O, one registered write per cycle.
// Starvation FSM raises stall_wb after STARVE_LIMIT refusals; REGFILE_ARB_STATS_EN adds grant/stall counters.
module regfile_write_arbiter #(
  parameter int STARVE_LIMIT = 4
`ifdef REGFILE_ARB_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input logic clock,
  input logic ctrl_reset,
  regfile_write_arbiter_if.slave bus
`ifdef REGFILE_ARB_STATS_EN
  , input  logic              stat_clear
  , output logic [STAT_W-1:0] stat_io_grants
  , output logic [STAT_W-1:0] stat_stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, STALL} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  localparam logic [4:0] RSTATUS = 5'd30;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, cnt_nxt;
  logic        exc_pend, exc_pend_nxt;
  logic [31:0] exc_buf;
  logic        exc_gnt, io_xfer, any_gnt, wr_en;
  logic [4:0]  sel_reg;
  logic [31:0] sel_data;

  // io_ready is forced low during reset so every output reads 0 while held
  assign bus.io_ready = ~ctrl_reset & bus.io_valid & ~bus.wb_we & ~exc_pend;
  assign io_xfer      = bus.io_ready;
  assign exc_gnt      = ~bus.wb_we & exc_pend;
  assign exc_pend_nxt = bus.exc_valid | (exc_pend & ~exc_gnt);

  always_comb begin
    sel_reg  = bus.wb_reg;
    sel_data = bus.wb_data;
    any_gnt  = 1'b0;
    if (bus.wb_we) begin
      any_gnt = 1'b1;
    end else if (exc_pend) begin
      sel_reg  = RSTATUS;
      sel_data = exc_buf;
      any_gnt  = 1'b1;
    end else if (io_xfer) begin
      sel_reg  = bus.io_reg;
      sel_data = bus.io_data;
      any_gnt  = 1'b1;
    end
    // writes to r0 still consume the grant but never reach the regfile
    wr_en = any_gnt & (sel_reg != 5'd0);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    case (state)
      IDLE: begin
        if (bus.io_valid & ~bus.io_ready) begin
          cnt_nxt   = 4'd1;
          state_nxt = (LIMIT == 4'd1) ? STALL : WAIT;
        end
      end
      WAIT: begin
        if (io_xfer | ~bus.io_valid) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = wait_cnt + 4'd1;
          if (cnt_nxt == LIMIT) state_nxt = STALL;
        end
      end
      STALL: begin
        // an abandoned request also releases the pipeline so it cannot deadlock
        if (io_xfer | ~bus.io_valid) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      exc_pend        <= 1'b0;
      exc_buf         <= 32'd0;
      bus.exc_overrun <= 1'b0;
    end else if (bus.exc_valid) begin
      exc_pend <= 1'b1;
      exc_buf  <= bus.exc_code;
      if (exc_pend & ~exc_gnt) bus.exc_overrun <= 1'b1;
    end else if (exc_gnt) begin
      exc_pend <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      bus.stall_wb         <= 1'b0;
      bus.ctrl_writeEnable <= 1'b0;
      bus.ctrl_writeReg    <= 5'd0;
      bus.data_writeReg    <= 32'd0;
    end else begin
      bus.stall_wb         <= (state_nxt == STALL) | (exc_pend_nxt & bus.wb_we);
      bus.ctrl_writeEnable <= wr_en;
      if (wr_en) begin
        bus.ctrl_writeReg <= sel_reg;
        bus.data_writeReg <= sel_data;
      end
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      stat_io_grants    <= '0;
      stat_stall_cycles <= '0;
    end else if (stat_clear) begin
      stat_io_grants    <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (io_xfer & ~&stat_io_grants) stat_io_grants <= stat_io_grants + 1'b1;
      if (bus.stall_wb & ~&stat_stall_cycles) stat_stall_cycles <= stat_stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a request-level model of the arbiter.
module tb_regfile_write_arbiter;
  localparam int LIMIT = 4;

  logic clock;
  logic ctrl_reset;
  int   n_checks;
  int   n_fail;

  regfile_write_arbiter_if bus ();

`ifdef REGFILE_ARB_STATS_EN
  logic        stat_clear;
  logic [15:0] stat_io_grants;
  logic [15:0] stat_stall_cycles;
  regfile_write_arbiter #(.STARVE_LIMIT(LIMIT), .STAT_W(16)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus),
    .stat_clear(stat_clear), .stat_io_grants(stat_io_grants), .stat_stall_cycles(stat_stall_cycles)
  );
`else
  regfile_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus)
  );
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the expected state of the registered outputs plus the pending exception and refusal run
  logic        m_we, m_pend, m_ovr, m_stall;
  logic [4:0]  m_reg;
  logic [31:0] m_data, m_exc;
  int          m_refused;

  initial begin
    logic        ready, g;
    logic [4:0]  r;
    logic [31:0] d;
    forever begin
      @(negedge clock);
      if (ctrl_reset) begin
        chk("rst_io_ready", {31'd0, bus.io_ready}, 32'd0);
        chk("rst_we", {31'd0, bus.ctrl_writeEnable}, 32'd0);
        chk("rst_stall", {31'd0, bus.stall_wb}, 32'd0);
        chk("rst_overrun", {31'd0, bus.exc_overrun}, 32'd0);
        chk("rst_data", bus.data_writeReg, 32'd0);
        m_we = 0; m_pend = 0; m_ovr = 0; m_stall = 0;
        m_reg = 0; m_data = 0; m_exc = 0; m_refused = 0;
      end else begin
        ready = bus.io_valid && !bus.wb_we && !m_pend;
        chk("m_we", {31'd0, bus.ctrl_writeEnable}, {31'd0, m_we});
        chk("m_reg", {27'd0, bus.ctrl_writeReg}, {27'd0, m_reg});
        chk("m_data", bus.data_writeReg, m_data);
        chk("m_stall", {31'd0, bus.stall_wb}, {31'd0, m_stall});
        chk("m_overrun", {31'd0, bus.exc_overrun}, {31'd0, m_ovr});
        chk("m_io_ready", {31'd0, bus.io_ready}, {31'd0, ready});
        g = 1; r = 0; d = 0;
        if (bus.wb_we) begin r = bus.wb_reg; d = bus.wb_data; end
        else if (m_pend) begin r = 5'd30; d = m_exc; end
        else if (ready) begin r = bus.io_reg; d = bus.io_data; end
        else g = 0;
        m_we = g && (r != 0);
        if (m_we) begin m_reg = r; m_data = d; end
        if (bus.exc_valid) begin
          if (m_pend && bus.wb_we) m_ovr = 1;
          m_pend = 1;
          m_exc  = bus.exc_code;
        end else if (!bus.wb_we) begin
          m_pend = 0;
        end
        if (bus.io_valid && !ready) m_refused = (m_refused < LIMIT) ? m_refused + 1 : LIMIT;
        else m_refused = 0;
        m_stall = (m_refused >= LIMIT) || (m_pend && bus.wb_we);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    bus.wb_we = 0; bus.wb_reg = 0; bus.wb_data = 0;
    bus.io_valid = 0; bus.io_reg = 0; bus.io_data = 0;
    bus.exc_valid = 0; bus.exc_code = 0;
  endtask

  initial begin
    logic acc;
    int   wb_burst;
    n_checks = 0;
    n_fail = 0;
    acc = 0;
    wb_burst = 0;
`ifdef REGFILE_ARB_STATS_EN
    stat_clear = 0;
`endif
    idle_inputs();
    ctrl_reset = 1;
    step(); step();
    ctrl_reset = 0;
    step();

    // single I/O write
    bus.io_valid = 1; bus.io_reg = 5; bus.io_data = 32'h0000ABCD;
    #1 chk("t1_io_ready", {31'd0, bus.io_ready}, 32'd1);
    step();
    chk("t1_we", {31'd0, bus.ctrl_writeEnable}, 32'd1);
    chk("t1_reg", {27'd0, bus.ctrl_writeReg}, 32'd5);
    chk("t1_data", bus.data_writeReg, 32'h0000ABCD);
    bus.io_valid = 0;

    // WB and I/O collide on reg 3
    step();
    bus.wb_we = 1; bus.wb_reg = 3; bus.wb_data = 32'h11;
    bus.io_valid = 1; bus.io_reg = 3; bus.io_data = 32'h22;
    #1 chk("t2_io_refused", {31'd0, bus.io_ready}, 32'd0);
    step();
    chk("t2_wb_data", bus.data_writeReg, 32'h11);
    bus.wb_we = 0;
    #1 chk("t2_io_ready", {31'd0, bus.io_ready}, 32'd1);
    step();
    chk("t2_io_data", bus.data_writeReg, 32'h22);
    chk("t2_io_reg", {27'd0, bus.ctrl_writeReg}, 32'd3);
    bus.io_valid = 0;

    // starvation: WB held high while I/O waits
    step();
    bus.wb_we = 1; bus.wb_reg = 7; bus.wb_data = 32'h77;
    bus.io_valid = 1; bus.io_reg = 9; bus.io_data = 32'h99;
    for (int i = 0; i < LIMIT; i++) begin
      step();
      if (i < LIMIT - 1) chk("t3_no_stall_yet", {31'd0, bus.stall_wb}, 32'd0);
    end
    chk("t3_stall", {31'd0, bus.stall_wb}, 32'd1);
    bus.wb_we = 0;
    #1 chk("t3_io_ready", {31'd0, bus.io_ready}, 32'd1);
    step();
    chk("t3_stall_clear", {31'd0, bus.stall_wb}, 32'd0);
    chk("t3_io_reg", {27'd0, bus.ctrl_writeReg}, 32'd9);
    bus.io_valid = 0;

    // exception blocked by WB for two cycles
    step();
    bus.exc_valid = 1; bus.exc_code = 32'h8;
    bus.wb_we = 1; bus.wb_reg = 4; bus.wb_data = 32'h44;
    step();
    bus.exc_valid = 0;
    chk("t4_stall_exc", {31'd0, bus.stall_wb}, 32'd1);
    step();
    bus.wb_we = 0;
    step();
    chk("t4_r30_we", {31'd0, bus.ctrl_writeEnable}, 32'd1);
    chk("t4_r30_reg", {27'd0, bus.ctrl_writeReg}, 32'd30);
    chk("t4_r30_data", bus.data_writeReg, 32'h8);
    chk("t4_no_overrun", {31'd0, bus.exc_overrun}, 32'd0);

    // second pulse while pending overwrites and flags overrun
    bus.exc_valid = 1; bus.exc_code = 32'h8; bus.wb_we = 1;
    step();
    bus.exc_code = 32'h10;
    step();
    bus.exc_valid = 0; bus.wb_we = 0;
    chk("t4_overrun", {31'd0, bus.exc_overrun}, 32'd1);
    step(); step();
    chk("t4_r30_new", bus.data_writeReg, 32'h10);

    // destination 0 is consumed without a write
    bus.io_valid = 1; bus.io_reg = 0; bus.io_data = 32'hDEAD;
    #1 chk("t5_io_ready", {31'd0, bus.io_ready}, 32'd1);
    step();
    bus.io_valid = 0;
    chk("t5_no_we", {31'd0, bus.ctrl_writeEnable}, 32'd0);

    // async reset in the middle of WAIT with an exception pending
    bus.wb_we = 1; bus.wb_reg = 2; bus.wb_data = 32'h5;
    bus.io_valid = 1; bus.io_reg = 6; bus.io_data = 32'h66;
    bus.exc_valid = 1; bus.exc_code = 32'h44;
    step();
    bus.exc_valid = 0;
    step();
    #1 ctrl_reset = 1;
    #1;
    chk("t6_we", {31'd0, bus.ctrl_writeEnable}, 32'd0);
    chk("t6_data", bus.data_writeReg, 32'd0);
    chk("t6_stall", {31'd0, bus.stall_wb}, 32'd0);
    chk("t6_io_ready", {31'd0, bus.io_ready}, 32'd0);
    idle_inputs();
    step();
    ctrl_reset = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_r30", {31'd0, bus.ctrl_writeEnable}, 32'd0);
    end

    // random traffic, protocol-respecting I/O, bursty WB
    for (int i = 0; i < 3000; i++) begin
      step();
      ctrl_reset = ((i % 1000) == 700);
      if (wb_burst > 0) begin
        bus.wb_we = 1;
        wb_burst--;
      end else if ($urandom_range(0, 7) == 0) begin
        wb_burst = $urandom_range(1, 8);
        bus.wb_we = 0;
      end else begin
        bus.wb_we = ($urandom_range(0, 3) == 0);
      end
      if (bus.stall_wb && $urandom_range(0, 7) != 0) bus.wb_we = 0;
      bus.wb_reg  = 5'($urandom_range(0, 31));
      bus.wb_data = $urandom;
      if (!bus.io_valid || acc || ctrl_reset) begin
        bus.io_valid = ($urandom_range(0, 2) != 0);
        bus.io_reg   = 5'($urandom_range(0, 31));
        bus.io_data  = $urandom;
      end
      bus.exc_valid = ($urandom_range(0, 11) == 0);
      bus.exc_code  = $urandom;
      if (bus.exc_code == 0) bus.exc_code = 32'h1;
      @(negedge clock);
      #1 acc = bus.io_valid && bus.io_ready;
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
